fetch_controller: RTL and testbench



---
 rtl/fetch_controller_pkg.sv | 18 +
 rtl/fetch_controller_if.sv | 36 +++
 rtl/fetch_queue.sv | 75 +++++++
 rtl/fetch_controller.sv | 83 ++++++++
 tb/tb_fetch_controller.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_pkg - shared types and constants for the dual-issue fetch unit     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package fetch_pkg;

  localparam int FETCH_WIDTH = 2;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr_a;
    logic [31:0] instr_b;
  } fetch_bundle_t;

endpackage
`default_nettype wire

// File: rtl/fetch_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_controller_if - control, imem and decode-side signals of fetch     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface fetch_controller_if #(
  parameter int QUEUE_DEPTH = 2
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic          fetch_en;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [31:0]   imem_addr_a;
  logic [31:0]   imem_addr_b;
  logic [31:0]   imem_data_a;
  logic [31:0]   imem_data_b;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr_a;
  logic [31:0]   out_instr_b;
  logic [CW-1:0] out_count;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, imem_data_a, imem_data_b, out_ready,
    output imem_addr_a, imem_addr_b, out_valid, out_pc, out_instr_a, out_instr_b, out_count
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, imem_data_a, imem_data_b, out_ready,
    input  imem_addr_a, imem_addr_b, out_valid, out_pc, out_instr_a, out_instr_b, out_count
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_queue - small FIFO of fetch bundles with flush and registered head |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_bundle_t push_data,
  input  logic          pop,
  output fetch_bundle_t head,
  output logic [CW-1:0] count
);

  fetch_bundle_t r_mem [DEPTH];
  fetch_bundle_t r_head;
  fetch_bundle_t w_head_next;
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [PW-1:0] w_rd_next;
  logic [PW-1:0] w_wr_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // The head register tracks whichever slot rd will point at next; when that
  // slot is being written this cycle the bypass supplies the new bundle.
  always_comb begin
    w_rd_next    = pop  ? ptr_inc(r_rd) : r_rd;
    w_wr_next    = push ? ptr_inc(r_wr) : r_wr;
    w_count_next = r_count + CW'(push) - CW'(pop);
    w_head_next  = (push && (r_wr == w_rd_next)) ? push_data : r_mem[w_rd_next];
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_rd    <= w_rd_next;
      r_wr    <= w_wr_next;
      r_count <= w_count_next;
      if (w_count_next != '0) r_head <= w_head_next;
    end
  end

  assign head  = r_head;
  assign count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && (r_count == CW'(DEPTH))));

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_controller - credit-based dual-issue fetch sequencer with redirect |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_controller_if.master bus
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int UW = CW + 1;

  logic [31:0]   r_pc;
  logic [31:0]   r_req_pc;
  logic          r_inflight;
  logic [31:0]   w_issue_pc;
  logic          w_out_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [UW-1:0] w_used;
  logic [CW-1:0] w_count;
  fetch_bundle_t w_push_data;
  fetch_bundle_t w_head;

  // A redirect empties the queue and kills the in-flight read, so the whole
  // credit budget is free to the target fetch in that same cycle.
  always_comb begin
    w_issue_pc  = bus.redirect_valid ? (bus.redirect_pc & ~32'h3) : r_pc;
    w_out_valid = (w_count != '0) & ~bus.redirect_valid;
    w_pop       = w_out_valid & bus.out_ready;
    w_push      = r_inflight & ~bus.redirect_valid;
    w_used      = UW'(w_count) + UW'(r_inflight) - UW'(w_pop);
    w_issue     = bus.fetch_en & (bus.redirect_valid | (w_used < UW'(QUEUE_DEPTH)));
    w_push_data = '{pc: r_req_pc, instr_a: bus.imem_data_a, instr_b: bus.imem_data_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc     <= w_issue_pc + 32'(FETCH_WIDTH * INSTR_BYTES);
        r_req_pc <= w_issue_pc;
      end else begin
        r_pc     <= w_issue_pc;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.redirect_valid),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count)
  );

  assign bus.imem_addr_a = w_issue_pc;
  assign bus.imem_addr_b = w_issue_pc + 32'(INSTR_BYTES);
  assign bus.out_valid   = w_out_valid;
  assign bus.out_pc      = w_head.pc;
  assign bus.out_instr_a = w_head.instr_a;
  assign bus.out_instr_b = w_head.instr_b;
  assign bus.out_count   = w_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_controller - directed vector bench for fetch_controller         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fetch_controller;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  fetch_controller_if #(.QUEUE_DEPTH(2)) bus0 ();
  fetch_controller_if #(.QUEUE_DEPTH(2)) bus1 ();

  fetch_controller #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word i holds 0x1000_0000 + i, one-cycle read latency.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {20'd0, a[13:2]};
  endfunction

  always @(posedge clk) begin
    bus0.imem_data_a <= mem_word(bus0.imem_addr_a);
    bus0.imem_data_b <= mem_word(bus0.imem_addr_b);
    bus1.imem_data_a <= mem_word(bus1.imem_addr_a);
    bus1.imem_data_b <= mem_word(bus1.imem_addr_b);
  end

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] ea;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ecnt;
  } vec_t;

  localparam int NROWS = 35;
  vec_t tbl [NROWS];

  task automatic v(input int i, input logic fe, input logic rdy, input logic redir,
                   input logic [31:0] rpc, input logic [31:0] ea, input logic ev,
                   input logic [31:0] epc, input logic [31:0] ecnt);
    tbl[i] = '{fe: fe, rdy: rdy, redir: redir, rpc: rpc, ea: ea, ev: ev, epc: epc, ecnt: ecnt};
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    bus0.fetch_en = 1'b0; bus0.out_ready = 1'b0;
    bus0.redirect_valid = 1'b0; bus0.redirect_pc = '0;
    bus1.fetch_en = 1'b1; bus1.out_ready = 1'b1;
    bus1.redirect_valid = 1'b0; bus1.redirect_pc = '0;

    //      i  fe rdy rd rpc        addr_a     v  pc         cnt
    v( 0, 1, 1, 0, 32'h0,   32'h000, 0, 32'h0,   0);
    v( 1, 1, 1, 0, 32'h0,   32'h008, 0, 32'h0,   0);
    v( 2, 1, 1, 0, 32'h0,   32'h010, 1, 32'h000, 1);
    v( 3, 1, 1, 0, 32'h0,   32'h018, 1, 32'h008, 1);
    v( 4, 1, 1, 0, 32'h0,   32'h020, 1, 32'h010, 1);
    v( 5, 1, 0, 0, 32'h0,   32'h028, 1, 32'h018, 1);
    for (int i = 6; i <= 10; i++) v(i, 1, 0, 0, 32'h0, 32'h028, 1, 32'h018, 2);
    v(11, 1, 1, 0, 32'h0,   32'h028, 1, 32'h018, 2);
    v(12, 1, 1, 0, 32'h0,   32'h030, 1, 32'h020, 1);
    v(13, 1, 1, 0, 32'h0,   32'h038, 1, 32'h028, 1);
    v(14, 1, 1, 0, 32'h0,   32'h040, 1, 32'h030, 1);
    v(15, 1, 0, 0, 32'h0,   32'h048, 1, 32'h038, 1);
    v(16, 1, 0, 0, 32'h0,   32'h048, 1, 32'h038, 2);
    v(17, 1, 1, 1, 32'h103, 32'h100, 0, 32'h0,   2);
    v(18, 1, 1, 0, 32'h0,   32'h108, 0, 32'h0,   0);
    v(19, 1, 1, 0, 32'h0,   32'h110, 1, 32'h100, 1);
    v(20, 1, 1, 0, 32'h0,   32'h118, 1, 32'h108, 1);
    v(21, 1, 1, 1, 32'h40,  32'h040, 0, 32'h0,   1);
    v(22, 1, 1, 0, 32'h0,   32'h048, 0, 32'h0,   0);
    v(23, 1, 1, 0, 32'h0,   32'h050, 1, 32'h040, 1);
    v(24, 0, 1, 0, 32'h0,   32'h058, 1, 32'h048, 1);
    v(25, 0, 1, 0, 32'h0,   32'h058, 1, 32'h050, 1);
    v(26, 0, 1, 0, 32'h0,   32'h058, 0, 32'h0,   0);
    v(27, 1, 1, 0, 32'h0,   32'h058, 0, 32'h0,   0);
    v(28, 1, 1, 0, 32'h0,   32'h060, 0, 32'h0,   0);
    v(29, 1, 1, 0, 32'h0,   32'h068, 1, 32'h058, 1);
    v(30, 0, 1, 1, 32'h200, 32'h200, 0, 32'h0,   1);
    v(31, 0, 1, 0, 32'h0,   32'h200, 0, 32'h0,   0);
    v(32, 1, 1, 0, 32'h0,   32'h200, 0, 32'h0,   0);
    v(33, 1, 1, 0, 32'h0,   32'h208, 0, 32'h0,   0);
    v(34, 1, 1, 0, 32'h0,   32'h210, 1, 32'h200, 1);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset valid",   32'(bus0.out_valid),   32'd0);
    chk("reset count",   32'(bus0.out_count),   32'd0);
    chk("reset out_pc",  bus0.out_pc,           32'd0);
    chk("reset instr_a", bus0.out_instr_a,      32'd0);
    chk("reset instr_b", bus0.out_instr_b,      32'd0);
    chk("reset addr_a",  bus0.imem_addr_a,      32'h0);
    chk("reset addr_a1", bus1.imem_addr_a,      32'hFFFF_FFF8);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NROWS; i++) begin
      if (i > 0) @(negedge clk);
      bus0.fetch_en       = tbl[i].fe;
      bus0.out_ready      = tbl[i].rdy;
      bus0.redirect_valid = tbl[i].redir;
      bus0.redirect_pc    = tbl[i].rpc;
      #1;
      chk($sformatf("r%0d addr_a", i), bus0.imem_addr_a, tbl[i].ea);
      chk($sformatf("r%0d addr_b", i), bus0.imem_addr_b, tbl[i].ea + 32'd4);
      chk($sformatf("r%0d valid", i),  32'(bus0.out_valid), 32'(tbl[i].ev));
      chk($sformatf("r%0d count", i),  32'(bus0.out_count), tbl[i].ecnt);
      if (tbl[i].ev) begin
        chk($sformatf("r%0d out_pc", i),  bus0.out_pc,      tbl[i].epc);
        chk($sformatf("r%0d instr_a", i), bus0.out_instr_a, mem_word(tbl[i].epc));
        chk($sformatf("r%0d instr_b", i), bus0.out_instr_b, mem_word(tbl[i].epc + 32'd4));
      end
    end

    // Asynchronous reset in the middle of a cycle while both units stream
    @(negedge clk);
    bus0.redirect_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async valid0",  32'(bus0.out_valid), 32'd0);
    chk("async count0",  32'(bus0.out_count), 32'd0);
    chk("async addr_a0", bus0.imem_addr_a,    32'h0);
    chk("async valid1",  32'(bus1.out_valid), 32'd0);
    chk("async count1",  32'(bus1.out_count), 32'd0);
    chk("async addr_a1", bus1.imem_addr_a,    32'hFFFF_FFF8);

    bus0.fetch_en  = 1'b1;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      case (k)
        0: begin
          chk("rs0 addr_a0", bus0.imem_addr_a, 32'h0);
          chk("rs0 addr_a1", bus1.imem_addr_a, 32'hFFFF_FFF8);
          chk("rs0 addr_b1", bus1.imem_addr_b, 32'hFFFF_FFFC);
        end
        1: begin
          chk("rs1 addr_a1", bus1.imem_addr_a, 32'h0);
          chk("rs1 valid1",  32'(bus1.out_valid), 32'd0);
        end
        2: begin
          chk("rs2 valid0",   32'(bus0.out_valid), 32'd1);
          chk("rs2 pc0",      bus0.out_pc,         32'h0);
          chk("rs2 instr_a0", bus0.out_instr_a,    32'h1000_0000);
          chk("rs2 instr_b0", bus0.out_instr_b,    32'h1000_0001);
          chk("rs2 valid1",   32'(bus1.out_valid), 32'd1);
          chk("rs2 pc1",      bus1.out_pc,         32'hFFFF_FFF8);
          chk("rs2 instr_a1", bus1.out_instr_a,    32'h1000_0FFE);
          chk("rs2 instr_b1", bus1.out_instr_b,    32'h1000_0FFF);
        end
        default: begin
          chk("rs3 pc0",      bus0.out_pc,      32'h8);
          chk("rs3 pc1",      bus1.out_pc,      32'h0);
          chk("rs3 instr_a1", bus1.out_instr_a, 32'h1000_0000);
          chk("rs3 instr_b1", bus1.out_instr_b, 32'h1000_0001);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
